// File: rtl/ram_arbiter.sv
// Round-robin arbiter and sequencer that lets two requesters share the single-port 1024x8 RAM.
// Commands are accepted with a valid/ready handshake and answered with a one-cycle response pulse.
module ram_arbiter #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req_valid_0,
  input  logic              req_we_0,
  input  logic [ADDR_W-1:0] req_addr_0,
  input  logic [DATA_W-1:0] req_wdata_0,
  output logic              req_ready_0,
  output logic              rsp_valid_0,

  input  logic              req_valid_1,
  input  logic              req_we_1,
  input  logic [ADDR_W-1:0] req_addr_1,
  input  logic [DATA_W-1:0] req_wdata_1,
  output logic              req_ready_1,
  output logic              rsp_valid_1,

  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,

  output logic              ram_write_enable,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
);

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StIssue    = 2'd1;
  localparam logic [1:0] StReadWait = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              prio_q, prio_d;
  logic              win_q, win_d;
  logic              wr_q, wr_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rsp0_q, rsp0_d;
  logic              rsp1_q, rsp1_d;

  logic idle;
  logic grant0;
  logic grant1;

  assign idle = (state_q == StIdle);

  // prio_q = 1 means requester 1 wins a tie.
  assign grant0 = req_valid_0 & (~req_valid_1 | ~prio_q);
  assign grant1 = req_valid_1 & ~grant0;

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    win_d       = win_q;
    wr_d        = wr_q;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    rdata_d     = rdata_q;
    rsp0_d      = 1'b0;
    rsp1_d      = 1'b0;

    case (state_q)
      StIdle: begin
        if (grant0 || grant1) begin
          win_d       = grant1;
          wr_d        = grant1 ? req_we_1 : req_we_0;
          ram_we_d    = grant1 ? req_we_1 : req_we_0;
          ram_addr_d  = grant1 ? req_addr_1 : req_addr_0;
          ram_wdata_d = grant1 ? req_wdata_1 : req_wdata_0;
          prio_d      = grant0;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        if (wr_q) begin
          rsp0_d  = ~win_q;
          rsp1_d  = win_q;
          state_d = StIdle;
        end else begin
          state_d = StReadWait;
        end
      end
      StReadWait: begin
        rdata_d = ram_data_out;
        rsp0_d  = ~win_q;
        rsp1_d  = win_q;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      prio_q      <= 1'b0;
      win_q       <= 1'b0;
      wr_q        <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rdata_q     <= '0;
      rsp0_q      <= 1'b0;
      rsp1_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      win_q       <= win_d;
      wr_q        <= wr_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      rdata_q     <= rdata_d;
      rsp0_q      <= rsp0_d;
      rsp1_q      <= rsp1_d;
    end
  end

  // Ready is gated by reset so every output reads 0 while rst_n is low.
  assign req_ready_0      = rst_n & idle & grant0;
  assign req_ready_1      = rst_n & idle & grant1;
  assign rsp_valid_0      = rsp0_q;
  assign rsp_valid_1      = rsp1_q;
  assign rsp_rdata        = rdata_q;
  assign busy             = ~idle;
  assign ram_write_enable = ram_we_q;
  assign ram_address      = ram_addr_q;
  assign ram_data_in      = ram_wdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 1024x8 registered-read RAM attached.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid_0, req_we_0, req_ready_0, rsp_valid_0;
  logic [9:0] req_addr_0;
  logic [7:0] req_wdata_0;
  logic       req_valid_1, req_we_1, req_ready_1, rsp_valid_1;
  logic [9:0] req_addr_1;
  logic [7:0] req_wdata_1;
  logic [7:0] rsp_rdata;
  logic       busy;
  logic       ram_write_enable;
  logic [9:0] ram_address;
  logic [7:0] ram_data_in;
  logic [7:0] ram_data_out;

  int checks = 0;
  int errors = 0;
  logic [7:0] last_rdata = 8'h00;

  logic       ram_clr;
  logic [7:0] mem [1024];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
      ram_data_out <= 8'h00;
    end else begin
      if (ram_write_enable) mem[ram_address] <= ram_data_in;
      ram_data_out <= mem[ram_address];
    end
  end

  ram_arbiter #(.ADDR_W(10), .DATA_W(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid_0      (req_valid_0),
    .req_we_0         (req_we_0),
    .req_addr_0       (req_addr_0),
    .req_wdata_0      (req_wdata_0),
    .req_ready_0      (req_ready_0),
    .rsp_valid_0      (rsp_valid_0),
    .req_valid_1      (req_valid_1),
    .req_we_1         (req_we_1),
    .req_addr_1       (req_addr_1),
    .req_wdata_1      (req_wdata_1),
    .req_ready_1      (req_ready_1),
    .rsp_valid_1      (rsp_valid_1),
    .rsp_rdata        (rsp_rdata),
    .busy             (busy),
    .ram_write_enable (ram_write_enable),
    .ram_address      (ram_address),
    .ram_data_in      (ram_data_in),
    .ram_data_out     (ram_data_out)
  );

  typedef struct {
    int         req;
    logic       we;
    logic [9:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int r, input logic v, input logic we, input logic [9:0] a,
                       input logic [7:0] d);
    if (r == 0) begin
      req_valid_0 = v; req_we_0 = we; req_addr_0 = a; req_wdata_0 = d;
    end else begin
      req_valid_1 = v; req_we_1 = we; req_addr_1 = a; req_wdata_1 = d;
    end
  endtask

  function automatic logic rdy(input int r);
    return (r == 0) ? req_ready_0 : req_ready_1;
  endfunction

  function automatic logic rsp(input int r);
    return (r == 0) ? rsp_valid_0 : rsp_valid_1;
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_ready0", req_ready_0, 0);
    chk("rst_ready1", req_ready_1, 0);
    chk("rst_rsp0", rsp_valid_0, 0);
    chk("rst_rsp1", rsp_valid_1, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_we", ram_write_enable, 0);
    chk("rst_addr", ram_address, 0);
    chk("rst_din", ram_data_in, 0);
    @(negedge clk);
    rst_n = 1'b1;
    last_rdata = 8'h00;
  endtask

  // One command from a single requester, checking every cycle of its latency.
  task automatic do_txn(input int r, input logic we, input logic [9:0] a, input logic [7:0] d,
                        input logic [7:0] exp);
    logic got;
    got = 1'b0;
    drive(r, 1'b1, we, a, d);
    for (int i = 0; i < 10; i++) begin
      #1;
      if (rdy(r)) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk($sformatf("accept_r%0d_a%0d", r, a), got, 1);
    if (!got) begin
      drive(r, 1'b0, 1'b0, 10'd0, 8'd0);
      return;
    end
    chk("other_ready_low", rdy(1 - r), 0);
    @(negedge clk);
    drive(r, 1'b0, 1'b0, 10'd0, 8'd0);
    #1;
    chk($sformatf("issue_we_a%0d", a), ram_write_enable, we);
    chk($sformatf("issue_addr_a%0d", a), ram_address, a);
    if (we) chk($sformatf("issue_din_a%0d", a), ram_data_in, d);
    chk("issue_busy", busy, 1);
    @(negedge clk);
    #1;
    chk("post_issue_we", ram_write_enable, 0);
    if (we) begin
      chk($sformatf("wr_rsp_r%0d", r), rsp(r), 1);
      chk("wr_rsp_other", rsp(1 - r), 0);
      chk("wr_rdata_hold", rsp_rdata, last_rdata);
    end else begin
      chk("rd_wait_rsp", rsp(r), 0);
      chk("rd_wait_busy", busy, 1);
      @(negedge clk);
      #1;
      chk($sformatf("rd_rsp_r%0d", r), rsp(r), 1);
      chk("rd_rsp_other", rsp(1 - r), 0);
      chk($sformatf("rd_data_a%0d", a), rsp_rdata, exp);
      last_rdata = exp;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, rk;
    logic e0, e1, er0, er1;

    vecs[0] = '{0, 1'b1, 10'd0,    8'hAA, 8'h00};
    vecs[1] = '{1, 1'b0, 10'd0,    8'h00, 8'hAA};
    vecs[2] = '{1, 1'b1, 10'd1023, 8'h5A, 8'h00};
    vecs[3] = '{0, 1'b0, 10'd1023, 8'h00, 8'h5A};
    vecs[4] = '{0, 1'b1, 10'd512,  8'h3C, 8'h00};
    vecs[5] = '{1, 1'b0, 10'd512,  8'h00, 8'h3C};
    vecs[6] = '{0, 1'b0, 10'd7,    8'h00, 8'h00};
    vecs[7] = '{1, 1'b1, 10'd0,    8'h11, 8'h00};
    vecs[8] = '{0, 1'b0, 10'd0,    8'h00, 8'h11};
    vecs[9] = '{1, 1'b0, 10'd1023, 8'h00, 8'h5A};

    rst_n = 1'b0;
    ram_clr = 1'b1;
    drive(0, 1'b0, 1'b0, 10'd0, 8'd0);
    drive(1, 1'b0, 1'b0, 10'd0, 8'd0);
    @(negedge clk);
    @(negedge clk);
    ram_clr = 1'b0;
    apply_reset();

    foreach (vecs[i]) do_txn(vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp);

    // Mid-simulation reset with a nonzero rsp_rdata; prio back to 0 for the collision.
    apply_reset();
    drive(0, 1'b1, 1'b1, 10'd50, 8'hBB);
    drive(1, 1'b1, 1'b1, 10'd1023, 8'hCC);
    #1;
    chk("col_ready0", req_ready_0, 1);
    chk("col_ready1_wait", req_ready_1, 0);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 10'd0, 8'd0);
    #1;
    chk("col_we0", ram_write_enable, 1);
    chk("col_addr0", ram_address, 50);
    chk("col_din0", ram_data_in, 8'hBB);
    chk("col_ready1_issue", req_ready_1, 0);
    @(negedge clk);
    #1;
    chk("col_rsp0", rsp_valid_0, 1);
    chk("col_ready1", req_ready_1, 1);
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 10'd0, 8'd0);
    #1;
    chk("col_we1", ram_write_enable, 1);
    chk("col_addr1", ram_address, 1023);
    chk("col_din1", ram_data_in, 8'hCC);
    @(negedge clk);
    #1;
    chk("col_rsp1", rsp_valid_1, 1);
    chk("col_rsp0_low", rsp_valid_0, 0);
    do_txn(1, 1'b0, 10'd50, 8'd0, 8'hBB);
    do_txn(0, 1'b0, 10'd1023, 8'd0, 8'hCC);

    // Both hold reads: grants alternate every 3 cycles starting with requester 0.
    apply_reset();
    drive(0, 1'b1, 1'b0, 10'd50, 8'd0);
    drive(1, 1'b1, 1'b0, 10'd1023, 8'd0);
    for (int c = 0; c < 20; c++) begin
      if (c == 18) begin
        drive(0, 1'b0, 1'b0, 10'd0, 8'd0);
        drive(1, 1'b0, 1'b0, 10'd0, 8'd0);
      end
      #1;
      k   = c / 3;
      rk  = k - 1;
      e0  = (c % 3 == 0) && (k < 6) && (k % 2 == 0);
      e1  = (c % 3 == 0) && (k < 6) && (k % 2 == 1);
      er0 = (c % 3 == 0) && (c >= 3) && (rk < 6) && (rk % 2 == 0);
      er1 = (c % 3 == 0) && (c >= 3) && (rk < 6) && (rk % 2 == 1);
      chk($sformatf("fair_rdy0_c%0d", c), req_ready_0, e0);
      chk($sformatf("fair_rdy1_c%0d", c), req_ready_1, e1);
      chk($sformatf("fair_rsp0_c%0d", c), rsp_valid_0, er0);
      chk($sformatf("fair_rsp1_c%0d", c), rsp_valid_1, er1);
      if (er0) chk($sformatf("fair_rdata0_c%0d", c), rsp_rdata, 8'hBB);
      if (er1) chk($sformatf("fair_rdata1_c%0d", c), rsp_rdata, 8'hCC);
      @(negedge clk);
    end
    last_rdata = 8'hCC;

    // Requester 1 pulses valid only during requester 0's ISSUE cycle.
    drive(0, 1'b1, 1'b1, 10'd9, 8'h77);
    #1;
    chk("wd_ready0", req_ready_0, 1);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) begin
        drive(0, 1'b0, 1'b0, 10'd0, 8'd0);
        drive(1, 1'b1, 1'b0, 10'd9, 8'd0);
        #1;
        chk("wd_ready1_pulse", req_ready_1, 0);
        drive(1, 1'b0, 1'b0, 10'd0, 8'd0);
      end
      #1;
      chk($sformatf("wd_ready1_c%0d", c), req_ready_1, 0);
      chk($sformatf("wd_we_c%0d", c), ram_write_enable, (c == 1));
      chk($sformatf("wd_rsp1_c%0d", c), rsp_valid_1, 0);
      chk($sformatf("wd_rsp0_c%0d", c), rsp_valid_0, (c == 2));
    end
    do_txn(1, 1'b0, 10'd9, 8'd0, 8'h77);

    // Reset lands during ISSUE of a write: nothing committed, no response.
    drive(0, 1'b1, 1'b1, 10'd5, 8'h55);
    #1;
    chk("rw_ready0", req_ready_0, 1);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 10'd0, 8'd0);
    #1;
    chk("rw_we_issue", ram_write_enable, 1);
    rst_n = 1'b0;
    #1;
    chk("rw_we_dropped", ram_write_enable, 0);
    chk("rw_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    last_rdata = 8'h00;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("rw_no_rsp_c%0d", c), rsp_valid_0, 0);
      chk($sformatf("rw_no_we_c%0d", c), ram_write_enable, 0);
      @(negedge clk);
    end
    do_txn(0, 1'b0, 10'd5, 8'd0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
